bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one RAMB16BWER port (32-bit wide, 14-bit address, byte-write enables) between two
//  requesters: M0 = CPU data side, M1 = program loader/debug. Per-cycle round-robin with a
//  bounded burst. Grants are issued in the same cycle as the RAM access. Read data returns one
//  cycle later with a per-master valid strobe.
// PARAMETERS
//  MAX_BURST   4    max consecutive grants to one master while the other waits (>=1)
//  CNT_W       16   width of the optional grant statistics counters
// PORTS
//  clk            in   1    single clock; also drives the RAM port clock
//  rst_n          in   1    synchronous reset, active-low
//  m0_req/m1_req  in   1    access request; addr/we/wdata must stay stable until gnt
//  m0_we/m1_we    in   4    byte write enables; 4'b0000 = read
//  m0_addr/m1_addr in  14   RAM port address (word select in [13:5], as the RAM uses it)
//  m0_wdata/m1_wdata in 32  write data
//  m0_gnt/m1_gnt  out  1    combinational; request issued to RAM this cycle
//  m0_rvalid/m1_rvalid out 1 registered; rdata valid for the read granted the previous cycle
//  rdata          out  32   = ram_dout, shared by both masters; qualified by rvalid
//  ram_en         out  1    = m0_gnt | m1_gnt
//  ram_we         out  4    we of the granted master; 0 when nothing is granted
//  ram_addr       out  14   addr of the granted master; 0 when idle
//  ram_din        out  32   wdata of the granted master; 0 when idle
//  ram_dout       in   32   RAM read data (1-cycle synchronous read)
//  stats_clr      in   1    clear statistics counters
//  m0_cnt/m1_cnt  out  CNT_W grant counters (feature only)
// BEHAVIOUR
//  - State registers: last (last-granted master, 1b), burst_cnt (grants to last since the owner switched), rv0/rv1.
//  - Reset (rst_n=0 at a clk edge): last=1 so M0 wins the first tie; burst_cnt=0; rvalid=0.
//    During reset gnt=0 and ram_en=0, ignoring req. A read granted the cycle before reset produces no rvalid.
//  - Arbitration each cycle:
//    - Only one master requests: that master is granted.
//    - Both request, and last requests with burst_cnt<MAX_BURST: last is granted again.
//    - Otherwise the non-last master is granted.
//    - At most one gnt per cycle. No requests: no gnt; last and burst_cnt hold.
//  - On a grant to master g: if g==last, burst_cnt=burst_cnt+1, saturating at MAX_BURST.
//    Otherwise last=g and burst_cnt=1.
//  - MAX_BURST=1 gives strict alternation under contention.
//  - Latency: gnt in cycle N. For a read (we==0), mX_rvalid=1 in cycle N+1 with rdata = word at addr.
//    A write produces no rvalid. Back-to-back reads are fully pipelined: 1 access per cycle.
//  - Same address, write in cycle N then read in N+1 (either master): the read returns the new data.
//  - A master that drops req before gnt withdraws the request with no side effect.
//    Keeping req high after gnt is a new request.
// CONFIGURATION
//  BRAM_ARB_STATS_EN defined:
//    - m0_cnt/m1_cnt are CNT_W-bit counters, +1 per grant to that master, saturating at all-ones.
//    - Cleared to 0 by reset or stats_clr. stats_clr has priority over the increment in the same cycle.
//  BRAM_ARB_STATS_EN undefined: m0_cnt/m1_cnt are tied to 0 and no counter logic exists.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles, req both 1 -> gnt=0, ram_en=0, rvalid=0.
//    First cycle after release: m0_gnt=1.
//  2 M0 only: write 0xDEADBEEF, we=4'hF, addr=14'h0020, then read addr 14'h0020.
//    -> m0_gnt both cycles; m0_rvalid the cycle after the read; rdata=0xDEADBEEF.
//  3 Byte write: we=4'b0010, wdata=0x0000AA00 to a word holding 0x11223344, then read
//    -> rdata=0x1122AA44.
//  4 Both req continuously, MAX_BURST=4 -> grant pattern M0 x4, M1 x4, M0 x4, ...
//    With MAX_BURST=1 -> strict alternation M0, M1, M0, ...
//  5 Reset mid-read: M1 read granted in cycle N, rst_n=0 in cycle N+1 -> m1_rvalid stays 0.
//  6 STATS_EN, 10 grants to M0 and 3 to M1, then stats_clr with a grant pending in the same cycle
//    -> before clear: m0_cnt=10, m1_cnt=3; next cycle: both 0.
//    With CNT_W=4 and 20 grants -> m0_cnt=15.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the two requester ports and the shared RAMB16 port seen by bram_port_arbiter.
// Ports: m0_*/m1_* request side (req, we, addr, wdata -> gnt, rvalid), rdata shared by both,
//        ram_* towards the block RAM (en, we, addr, din -> dout). slave = arbiter, master = environment.
interface bram_port_arbiter_if;
  logic        m0_req;
  logic [3:0]  m0_we;
  logic [13:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;

  logic        m1_req;
  logic [3:0]  m1_we;
  logic [13:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;

  logic [31:0] rdata;

  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_dout,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output ram_en, ram_we, ram_addr, ram_din
  );

  // Requesters plus the RAM model.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_dout,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input  ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-master round-robin arbiter with bounded bursts in front of one 32-bit RAMB16 port.
// Latency: grant and RAM access in the same cycle (combinational gnt), read data + rvalid one cycle later.
// Backpressure: a requester holds req/addr/we/wdata until gnt; a losing master simply waits.
// Ports: clk, rst_n (synchronous, active-low), stats_clr, bus (bram_port_arbiter_if.slave),
//        m0_cnt/m1_cnt grant counters.
// Optional grant statistics are compiled in when BRAM_ARB_STATS_EN is defined; otherwise the
// counter outputs are tied to zero.
module bram_port_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stats_clr,
  bram_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0]   m0_cnt,
  output logic [CNT_W-1:0]   m1_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic          last_q, last_d;   // last-granted master (1 = M1)
  logic [BW-1:0] burst_q, burst_d; // consecutive grants to last_q, saturating
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;

  logic gnt0, gnt1;
  logic keep_last;
  logic pick_m1;

  // Arbitration. burst_q == 0 only after reset, when nobody has been granted yet;
  // the reset value last_q = 1 then makes M0 win the first tie.
  always_comb begin
    keep_last = (burst_q != '0) && (burst_q < BURST_MAX);
    pick_m1   = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (rst_n) begin
      if (bus.m0_req && bus.m1_req) begin
        pick_m1 = keep_last ? last_q : ~last_q;
        gnt0    = ~pick_m1;
        gnt1    = pick_m1;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  // Burst bookkeeping and read-return strobes.
  always_comb begin
    last_d  = last_q;
    burst_d = burst_q;
    if (gnt0 || gnt1) begin
      if (gnt1 == last_q) begin
        if (burst_q < BURST_MAX) burst_d = burst_q + BW'(1);
      end else begin
        last_d  = gnt1;
        burst_d = BW'(1);
      end
    end
    rv0_d = gnt0 && (bus.m0_we == 4'h0);
    rv1_d = gnt1 && (bus.m1_we == 4'h0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      burst_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  // RAM port mux: everything is zero when idle so the RAM sees a clean bus.
  always_comb begin
    bus.ram_en   = gnt0 | gnt1;
    bus.ram_we   = 4'h0;
    bus.ram_addr = 14'h0;
    bus.ram_din  = 32'h0;
    if (gnt0) begin
      bus.ram_we   = bus.m0_we;
      bus.ram_addr = bus.m0_addr;
      bus.ram_din  = bus.m0_wdata;
    end else if (gnt1) begin
      bus.ram_we   = bus.m1_we;
      bus.ram_addr = bus.m1_addr;
      bus.ram_din  = bus.m1_wdata;
    end
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;
  assign bus.rdata  = bus.ram_dout;
  // Gating with rst_n kills the strobe of a read granted just before reset asserts.
  assign bus.m0_rvalid = rv0_q & rst_n;
  assign bus.m1_rvalid = rv1_q & rst_n;

`ifdef BRAM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Saturating grant counters; clear wins over a same-cycle grant.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (gnt0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
      if (gnt1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign m0_cnt = cnt0_q;
  assign m1_cnt = cnt1_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign m0_cnt = '0;
  assign m1_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed reset/read/write/burst/stats steps followed by a
// randomized phase, all checked against a transaction-level reference model.
// A second instance with MAX_BURST=1, CNT_W=4 covers strict alternation and counter saturation.
module tb_bram_port_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst1_n = 1'b0;
  logic stats_clr = 1'b0;
  logic stats_clr1 = 1'b0;
  logic [15:0] m0_cnt, m1_cnt;
  logic [3:0]  m0_cnt1, m1_cnt1;

  always #5 clk = ~clk;

  bram_port_arbiter_if ifc ();
  bram_port_arbiter_if ifc1 ();

  bram_port_arbiter #(.MAX_BURST(MAXB), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .stats_clr(stats_clr), .bus(ifc),
    .m0_cnt(m0_cnt), .m1_cnt(m1_cnt));

  bram_port_arbiter #(.MAX_BURST(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .stats_clr(stats_clr1), .bus(ifc1),
    .m0_cnt(m0_cnt1), .m1_cnt(m1_cnt1));

  // Block RAM behaviour: 512 x 32, addr[13:5] selects the word, 1-cycle synchronous read.
  logic [31:0] ram [0:511] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ifc.ram_en) begin
      ifc.ram_dout <= ram[ifc.ram_addr[13:5]];
      for (int b = 0; b < 4; b++)
        if (ifc.ram_we[b]) ram[ifc.ram_addr[13:5]][8*b +: 8] <= ifc.ram_din[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] exp_mem [0:511] = '{default: 32'h0};
  int m_owner = -1;      // master that holds the current run, -1 = none since reset
  int m_run   = 0;       // grants in the current run (not saturated)
  int m_rv    = -1;      // master expecting rvalid this cycle, -1 = none
  int mwin    = -1;
  logic [31:0] m_rdata = 32'h0;
  int unsigned m_c0 = 0, m_c1 = 0;

  int checks = 0, passed = 0, fails = 0;

  // Stimulus for the current step.
  logic r0 = 1'b0, r1 = 1'b0, clr = 1'b0;
  logic [3:0]  w0 = 4'h0, w1 = 4'h0;
  logic [13:0] a0 = 14'h0, a1 = 14'h0;
  logic [31:0] d0 = 32'h0, d1 = 32'h0;
  logic obs_g0, obs_g1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  // Who should win: a lone requester always; under contention the run owner keeps the port
  // until it has had MAXB grants in a row, and M0 wins when nobody owns a run yet.
  function automatic int predict(input logic q0, input logic q1);
    if (!q0 && !q1) return -1;
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    if (m_owner >= 0 && m_run < MAXB) return m_owner;
    return (m_owner == 0) ? 1 : 0;
  endfunction

  task automatic step();
    logic [3:0]  ew;
    logic [13:0] ea;
    logic [31:0] ed;
    @(negedge clk);
    rst_n = 1'b1;
    ifc.m0_req = r0; ifc.m0_we = w0; ifc.m0_addr = a0; ifc.m0_wdata = d0;
    ifc.m1_req = r1; ifc.m1_we = w1; ifc.m1_addr = a1; ifc.m1_wdata = d1;
    stats_clr = clr;
    #1;
    check("m0_rvalid", ifc.m0_rvalid, m_rv == 0);
    check("m1_rvalid", ifc.m1_rvalid, m_rv == 1);
    if (m_rv >= 0) check("rdata", ifc.rdata, m_rdata);
    mwin = predict(r0, r1);
    ew = 4'h0; ea = 14'h0; ed = 32'h0;
    if (mwin == 0) begin ew = w0; ea = a0; ed = d0; end
    else if (mwin == 1) begin ew = w1; ea = a1; ed = d1; end
    check("m0_gnt", ifc.m0_gnt, mwin == 0);
    check("m1_gnt", ifc.m1_gnt, mwin == 1);
    check("ram_en", ifc.ram_en, mwin >= 0);
    check("ram_we", ifc.ram_we, ew);
    check("ram_addr", ifc.ram_addr, ea);
    check("ram_din", ifc.ram_din, ed);
`ifdef BRAM_ARB_STATS_EN
    check("m0_cnt", m0_cnt, m_c0);
    check("m1_cnt", m1_cnt, m_c1);
    if (clr) begin
      m_c0 = 0; m_c1 = 0;
    end else begin
      if (mwin == 0 && m_c0 < 65535) m_c0++;
      if (mwin == 1 && m_c1 < 65535) m_c1++;
    end
`else
    check("m0_cnt_tied", m0_cnt, 32'h0);
    check("m1_cnt_tied", m1_cnt, 32'h0);
`endif
    obs_g0 = ifc.m0_gnt;
    obs_g1 = ifc.m1_gnt;
    m_rv = -1;
    if (mwin >= 0) begin
      if (mwin == m_owner) m_run++;
      else begin m_owner = mwin; m_run = 1; end
      if (ew == 4'h0) begin
        m_rv = mwin;
        m_rdata = exp_mem[ea[13:5]];
      end else begin
        exp_mem[ea[13:5]] = merge(exp_mem[ea[13:5]], ed, ew);
      end
    end
  endtask

  task automatic drive(input logic q0, input logic [3:0] e0, input logic [13:0] b0,
                       input logic [31:0] v0, input logic q1, input logic [3:0] e1,
                       input logic [13:0] b1, input logic [31:0] v1);
    r0 = q0; w0 = e0; a0 = b0; d0 = v0;
    r1 = q1; w1 = e1; a1 = b1; d1 = v1;
    step();
  endtask

  // One cycle of reset, asserted just after the edge that closes the previous step.
  task automatic rst_step();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ifc.m0_req = 1'b1;
    ifc.m1_req = 1'b1;
    @(negedge clk);
    #1;
    check("rst_m0_gnt", ifc.m0_gnt, 1'b0);
    check("rst_m1_gnt", ifc.m1_gnt, 1'b0);
    check("rst_ram_en", ifc.ram_en, 1'b0);
    check("rst_m0_rvalid", ifc.m0_rvalid, 1'b0);
    check("rst_m1_rvalid", ifc.m1_rvalid, 1'b0);
    m_owner = -1; m_run = 0; m_rv = -1; m_c0 = 0; m_c1 = 0;
  endtask

  initial begin
    ifc.m0_req = 1'b1; ifc.m0_we = 4'h0; ifc.m0_addr = 14'h0; ifc.m0_wdata = 32'h0;
    ifc.m1_req = 1'b1; ifc.m1_we = 4'h0; ifc.m1_addr = 14'h0; ifc.m1_wdata = 32'h0;
    ifc1.m0_req = 1'b0; ifc1.m0_we = 4'h0; ifc1.m0_addr = 14'h0; ifc1.m0_wdata = 32'h0;
    ifc1.m1_req = 1'b0; ifc1.m1_we = 4'h0; ifc1.m1_addr = 14'h0; ifc1.m1_wdata = 32'h0;
    ifc1.ram_dout = 32'h0;

    // Reset held three cycles with both masters requesting.
    repeat (3) rst_step();

    // First tie after reset goes to M0 (write 0xDEADBEEF to 0x0020); M1 waits with a read.
    drive(1'b1, 4'hF, 14'h0020, 32'hDEADBEEF, 1'b1, 4'h0, 14'h0040, 32'h0);
    check("first_tie_m0", obs_g0, 1'b1);
    drive(1'b1, 4'h0, 14'h0020, 32'h0, 1'b1, 4'h0, 14'h0040, 32'h0);
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 4'h0, 14'h0040, 32'h0);
    check("read_back", ifc.rdata, 32'hDEADBEEF);

    // Byte-lane write merge.
    drive(1'b1, 4'hF, 14'h0060, 32'h11223344, 1'b0, 4'h0, 14'h0, 32'h0);
    drive(1'b1, 4'b0010, 14'h0060, 32'h0000AA00, 1'b0, 4'h0, 14'h0, 32'h0);
    drive(1'b1, 4'h0, 14'h0060, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
    check("byte_merge", ifc.rdata, 32'h1122AA44);

    // M1 read granted, then reset: its rvalid must never appear.
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 4'h0, 14'h0060, 32'h0);
    rst_step();
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
    check("no_rvalid_after_rst", ifc.m1_rvalid, 1'b0);

    // Continuous contention: runs of four.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'h0, 14'h0020, 32'h0, 1'b1, 4'h0, 14'h0060, 32'h0);
      check("burst_pattern", obs_g1, ((i / 4) % 2) == 1);
    end

    // Statistics: 10 grants to M0, 3 to M1, then a clear racing a grant.
    rst_step();
    for (int i = 0; i < 10; i++)
      drive(1'b1, 4'hF, 14'(i << 5), 32'($urandom), 1'b0, 4'h0, 14'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 4'h0, 14'(i << 5), 32'h0);
    clr = 1'b1;
    drive(1'b1, 4'h0, 14'h0020, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
`ifdef BRAM_ARB_STATS_EN
    check("cnt0_before_clr", m0_cnt, 32'd10);
    check("cnt1_before_clr", m1_cnt, 32'd3);
`endif
    clr = 1'b0;
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
`ifdef BRAM_ARB_STATS_EN
    check("cnt0_after_clr", m0_cnt, 32'd0);
    check("cnt1_after_clr", m1_cnt, 32'd0);
`endif

    // Randomized traffic; a pending request stays stable unless it is withdrawn.
    for (int i = 0; i < 300; i++) begin
      if (r0 && mwin != 0) begin
        if ($urandom_range(7) == 0) r0 = 1'b0;
      end else begin
        r0 = ($urandom_range(2) != 0);
        w0 = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
        a0 = 14'($urandom_range(7) << 5) | 14'($urandom_range(31));
        d0 = $urandom;
      end
      if (r1 && mwin != 1) begin
        if ($urandom_range(7) == 0) r1 = 1'b0;
      end else begin
        r1 = ($urandom_range(2) != 0);
        w1 = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
        a1 = 14'($urandom_range(7) << 5) | 14'($urandom_range(31));
        d1 = $urandom;
      end
      clr = ($urandom_range(31) == 0);
      step();
    end
    clr = 1'b0;
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);

    // MAX_BURST=1 instance: strict alternation, then 4-bit counter saturation.
    ifc1.m0_req = 1'b1;
    ifc1.m1_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("alt_m0_gnt", ifc1.m0_gnt, (i % 2) == 0);
      check("alt_m1_gnt", ifc1.m1_gnt, (i % 2) == 1);
      @(negedge clk);
    end
    ifc1.m0_req = 1'b0;
    ifc1.m1_req = 1'b0;
    stats_clr1 = 1'b1;
    @(negedge clk);
    stats_clr1 = 1'b0;
    ifc1.m0_req = 1'b1;
    repeat (20) @(negedge clk);
    ifc1.m0_req = 1'b0;
    #1;
`ifdef BRAM_ARB_STATS_EN
    check("cnt_saturate", m0_cnt1, 32'd15);
    check("cnt_other_zero", m1_cnt1, 32'd0);
`else
    check("cnt1_tied", m0_cnt1, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
